// File: rtl/clk_ratio_checker.sv
// clk_ratio_checker: qualifies a divided clock sampled on clk16f against
// the divide ratio on ratio_sel; locks after LOCK_CNT good periods.
//
// Ports:
//   clk16f     in   fastest clock, all logic on its rising edge
//   reset_L    in   asynchronous reset, active-low
//   clk_in     in   divided clock under test (synchronous to clk16f)
//   ratio_sel  in   [1:0] 0=/4 1=/8 2=/16 3=reserved (never locks)
//   locked     out  high while the ratio is verified
//   err        out  one-cycle pulse per bad period seen while locked
//   err_count  out  [7:0] saturating count of err pulses
//
// Build option: define CLKCHK_ERRCNT_EN to implement err_count;
// otherwise err_count is tied to zero.
module clk_ratio_checker #(
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 6
) (
  input  logic       clk16f,
  input  logic       reset_L,
  input  logic       clk_in,
  input  logic [1:0] ratio_sel,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [GW-1:0]    good_q, good_d;
  logic             clk_in_d;
  logic [1:0]       ratio_q;
  logic             ratio_vld;
  logic             locked_d;
  logic             err_d;

  logic [CNT_W-1:0] p_val;
  logic [CNT_W-1:0] h_val;
  logic [CNT_W-1:0] p2_val;
  logic             p_ok;
  logic             rise;
  logic             sel_chg;
  logic             tmo;
  logic             per_ok;
  logic             per_bad;

  always_comb begin
    p_val = '0;
    p_ok  = 1'b1;
    unique case (ratio_sel)
      2'd0:    p_val = CNT_W'(4);
      2'd1:    p_val = CNT_W'(8);
      2'd2:    p_val = CNT_W'(16);
      default: p_ok  = 1'b0;
    endcase
  end

  assign h_val  = p_val >> 1;
  assign p2_val = p_val << 1;

  assign rise = clk_in & ~clk_in_d;

  // ratio_vld keeps the first cycle after reset from
  // looking like a ratio change
  assign sel_chg = ratio_vld & (ratio_sel != ratio_q);

  assign tmo     = p_ok & ~rise & (cnt_q == p2_val);
  assign per_ok  = rise & p_ok
                 & (cnt_q == p_val) & (hi_q == h_val);
  assign per_bad = (rise & ~per_ok) | tmo;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (sel_chg) begin
      cnt_d = '0;
      hi_d  = '0;
    end else if (rise) begin
      cnt_d = C_ONE;
      hi_d  = C_ONE;
    end else if (tmo) begin
      cnt_d = C_ONE;
      hi_d  = '0;
    end else begin
      if (!(&cnt_q))
        cnt_d = cnt_q + C_ONE;
      if (clk_in && !(&hi_q))
        hi_d = hi_q + C_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (sel_chg) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // first rise only sets the reference edge
          if (rise) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ: begin
          if (per_ok) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_ONE;
            end
          end else if (per_bad) begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (per_bad) begin
            err_d   = 1'b1;
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      good_q    <= '0;
      clk_in_d  <= 1'b0;
      ratio_q   <= 2'd0;
      ratio_vld <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      good_q    <= good_d;
      clk_in_d  <= clk_in;
      ratio_q   <= ratio_sel;
      ratio_vld <= 1'b1;
      locked    <= locked_d;
      err       <= err_d;
    end
  end

`ifdef CLKCHK_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L)
      err_cnt_q <= 8'd0;
    else if (err_d && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_clk_ratio_checker.sv
// tb_clk_ratio_checker: scoreboard bench for clk_ratio_checker.
// Reference model works on edge timestamps and high-sample counts.
module tb_clk_ratio_checker;

  localparam int LOCK_CNT = 4;
`ifdef CLKCHK_ERRCNT_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  logic       clk16f = 1'b0;
  logic       reset_L = 1'b0;
  logic       clk_in = 1'b0;
  logic [1:0] ratio_sel = 2'd2;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  clk_ratio_checker #(
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (6)
  ) dut (
    .clk16f    (clk16f),
    .reset_L   (reset_L),
    .clk_in    (clk_in),
    .ratio_sel (ratio_sel),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk16f = ~clk16f;

  int cyc = 0;
  always @(posedge clk16f) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       lck;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int         m_state;   // 0 idle, 1 acquiring, 2 locked
  int         m_good;
  int         m_t;
  int         m_ref;     // timestamp of current reference edge
  int         m_hi;      // high samples since the reference edge
  logic       m_prev_c;
  logic [1:0] m_prev_r;
  bit         m_have_r;
  int         m_ecnt;
  bit         m_err;

  function automatic void chk(string name, logic [7:0] act,
                              logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t actual=%0d required=%0d",
               name, $time, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_state  = 0;
    m_good   = 0;
    m_t      = 0;
    m_ref    = 0;
    m_hi     = 0;
    m_prev_c = 1'b0;
    m_prev_r = 2'd0;
    m_have_r = 1'b0;
    m_ecnt   = 0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_step(logic c, logic [1:0] r);
    bit rise, gp, bp;
    int p;
    exp_t e;
    m_err = 1'b0;
    rise  = c && !m_prev_c;
    p     = (r == 2'd0) ? 4 : (r == 2'd1) ? 8 : (r == 2'd2) ? 16 : 0;
    gp    = 1'b0;
    bp    = 1'b0;
    if (m_have_r && r != m_prev_r) begin
      m_state = 0;
      m_good  = 0;
    end else if (m_state == 0) begin
      if (rise) begin
        m_state = 1;
        m_good  = 0;
        m_ref   = m_t;
        m_hi    = 1;
      end
    end else begin
      if (rise) begin
        if (p != 0 && (m_t - m_ref) == p && m_hi == p / 2) gp = 1'b1;
        else bp = 1'b1;
        m_ref = m_t;
        m_hi  = 1;
      end else if (p != 0 && (m_t - m_ref) == 2 * p) begin
        bp    = 1'b1;
        m_ref = m_t;
        m_hi  = 0;
      end else if (c) begin
        m_hi++;
      end
      if (m_state == 1) begin
        if (gp) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_state = 2;
            m_good  = 0;
          end
        end else if (bp) begin
          m_good = 0;
        end
      end else if (bp) begin
        m_err   = 1'b1;
        m_state = 1;
        m_good  = 0;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
    m_prev_c = c;
    m_prev_r = r;
    m_have_r = 1'b1;
    m_t++;
    e.due = cyc + 1;
    e.lck = (m_state == 2);
    e.er  = m_err;
    e.ec  = ERRC ? 8'(m_ecnt) : 8'd0;
    q.push_back(e);
  endfunction

  // monitor: compares every expectation whose cycle has come
  always @(negedge clk16f) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("locked", 8'(locked), 8'(e.lck));
      chk("err", 8'(err), 8'(e.er));
      chk("err_count", err_count, e.ec);
    end
  end

  logic [1:0] cur_r = 2'd2;

  task automatic step(input logic c, input logic [1:0] r);
    @(posedge clk16f);
    #1;
    clk_in    = c;
    ratio_sel = r;
    model_step(c, r);
  endtask

  task automatic clean(input int p, input int h, input int n,
                       input logic [1:0] r);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        step(i < h, r);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk16f);
    #3;
    reset_L = 1'b0;
    clk_in  = 1'b0;
    #1;
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_err_count", err_count, 8'd0);
    q.delete();
    model_reset();
    repeat (hold) @(posedge clk16f);
    @(negedge clk16f);
    reset_L   = 1'b1;
    ratio_sel = cur_r;
    model_step(1'b0, cur_r);
  endtask

  function automatic int per_of(logic [1:0] r);
    return (r == 2'd3) ? 8 : (4 << r);
  endfunction

  initial begin : stim
    int mode, n, len, h;
    logic lvl;
    model_reset();
    reset_L   = 1'b0;
    clk_in    = 1'b0;
    ratio_sel = cur_r;
    repeat (3) @(posedge clk16f);
    #1;
    chk("init_locked", 8'(locked), 8'd0);
    chk("init_err", 8'(err), 8'd0);
    chk("init_err_count", err_count, 8'd0);
    @(negedge clk16f);
    reset_L = 1'b1;
    model_step(1'b0, cur_r);

    // clean /16, lock
    clean(16, 8, 6, 2'd2);
    // /16 clock checked as /4: never locks
    cur_r = 2'd0;
    clean(16, 8, 32, cur_r);
    // /4 lock, one stretched period, relock
    clean(4, 2, 8, cur_r);
    clean(5, 2, 1, cur_r);
    clean(4, 2, 8, cur_r);
    // /8 lock then held low
    cur_r = 2'd1;
    clean(8, 4, 7, cur_r);
    repeat (40) step(1'b0, cur_r);
    clean(8, 4, 7, cur_r);
    // /16 with high time 9
    cur_r = 2'd2;
    clean(16, 9, 10, cur_r);
    // reserved ratio
    cur_r = 2'd3;
    clean(8, 4, 10, cur_r);
    clean(16, 8, 6, cur_r);
    // /16 locked, reset mid-period, relock
    cur_r = 2'd2;
    clean(16, 8, 6, cur_r);
    for (int i = 0; i < 7; i++) step(i < 8, cur_r);
    do_reset(2);
    clean(16, 8, 7, cur_r);

    // randomized phase
    for (int it = 0; it < 160; it++) begin
      mode = $urandom_range(0, 6);
      case (mode)
        0, 1, 2: begin
          n = $urandom_range(1, 7);
          clean(per_of(cur_r), per_of(cur_r) / 2, n, cur_r);
        end
        3: begin
          len = $urandom_range(2, 20);
          h   = $urandom_range(1, len - 1);
          clean(len, h, 1, cur_r);
        end
        4: begin
          lvl = 1'($urandom_range(0, 1));
          n   = $urandom_range(1, 40);
          repeat (n) step(lvl, cur_r);
        end
        5: begin
          cur_r = 2'($urandom_range(0, 3));
          step(clk_in, cur_r);
        end
        default: begin
          n = $urandom_range(1, 20);
          repeat (n) step(1'($urandom_range(0, 1)), cur_r);
        end
      endcase
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
    end

    repeat (4) @(posedge clk16f);
    @(negedge clk16f);
    #1;
    chk("drain", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
